// File: rtl/cd_pkg.sv
// cd_pkg: shared definitions for the frame-page controller.
//   CD_PAGE_NUM_DFT / CD_PAGE_AW_DFT : default geometry (4 pages of 256 bytes)
//   PAGE_W / RAM_AW                  : page-select and full RAM address widths
//                                      for the default geometry
//   len_t                            : frame length element (0 .. 2**PAGE_AW)
package cd_pkg;

  localparam int CD_PAGE_NUM_DFT = 4;
  localparam int CD_PAGE_AW_DFT  = 8;

  localparam int PAGE_W = $clog2(CD_PAGE_NUM_DFT);
  localparam int RAM_AW = PAGE_W + CD_PAGE_AW_DFT;

  // One extra bit so a completely full page (2**PAGE_AW bytes) is representable.
  typedef logic [CD_PAGE_AW_DFT:0] len_t;

  // Page-select width for an arbitrary page count.
  function automatic int cd_page_w(input int page_num);
    return $clog2(page_num);
  endfunction

endpackage

// File: rtl/cd_sdpram.sv
// cd_sdpram: simple dual-port RAM, one write port and one registered read port.
//   clk   : clock
//   cen   : chip enable, active low (gates both ports)
//   wen   : write enable, active low
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, valid one cycle after raddr is presented
module cd_sdpram #(
  parameter int A_WIDTH = 10,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               cen,
  input  logic               wen,
  input  logic [A_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic [A_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];

  always_ff @(posedge clk) begin
    if (!cen && !wen) mem[waddr] <= wdata;
    if (!cen)         rdata      <= mem[raddr];
  end

endmodule

// File: rtl/cd_page_ctrl.sv
// cd_page_ctrl: splits an internal RAM into PAGE_NUM pages run as a circular
// queue of frames. The writer fills the head page and commits/aborts it; the
// reader indexes bytes of the oldest committed frame and releases it.
//   clk, reset           : clock, synchronous active-high reset
//   wr_vld, wr_data      : writer byte strobe and data
//   wr_commit, wr_abort  : close-and-queue / discard the frame being written
//   wr_rdy               : a free page exists
//   wr_drop              : one-cycle pulse when a commit was rejected
//   rd_avail, rd_len     : a frame is queued / length of the oldest frame
//   rd_req, rd_idx       : read byte rd_idx of the oldest frame
//   rd_dvld, rd_data     : read response, one cycle after rd_req
//   rd_done              : release the oldest frame
//   pend_cnt             : number of committed frames
module cd_page_ctrl
  import cd_pkg::*;
#(
  parameter int PAGE_NUM = CD_PAGE_NUM_DFT,
  parameter int PAGE_AW  = CD_PAGE_AW_DFT,
  parameter int D_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_vld,
  input  logic [D_WIDTH-1:0]          wr_data,
  input  logic                        wr_commit,
  input  logic                        wr_abort,
  output logic                        wr_rdy,
  output logic                        wr_drop,
  output logic                        rd_avail,
  output logic [PAGE_AW:0]            rd_len,
  input  logic                        rd_req,
  input  logic [PAGE_AW-1:0]          rd_idx,
  output logic                        rd_dvld,
  output logic [D_WIDTH-1:0]          rd_data,
  input  logic                        rd_done,
  output logic [$clog2(PAGE_NUM):0]   pend_cnt
);

  localparam int PG_W = cd_page_w(PAGE_NUM);
  localparam int A_W  = PG_W + PAGE_AW;
  localparam logic [PG_W:0] PEND_FULL = (PG_W+1)'(PAGE_NUM);

  logic [PG_W-1:0]    wr_ptr, rd_ptr;
  logic [PAGE_AW:0]   wr_cnt, cnt_eff;
  logic               ovf, ovf_eff;
  logic [PAGE_AW:0]   len_q [PAGE_NUM];
  logic               acc, commit_ok, commit_bad, rel;
  logic [D_WIDTH-1:0] ram_q;

  assign wr_rdy   = (pend_cnt != PEND_FULL);
  assign rd_avail = (pend_cnt != '0);
  assign rd_len   = len_q[rd_ptr];

  // A byte is stored only while the page has room and a page is free; any
  // other byte poisons the frame so its commit is rejected.
  assign acc     = wr_vld && wr_rdy && !wr_cnt[PAGE_AW];
  assign ovf_eff = ovf || (wr_vld && !acc);
  // Count as seen by a same-cycle commit, so that byte is part of the frame.
  assign cnt_eff = wr_cnt + (PAGE_AW+1)'(acc);

  assign commit_ok  = wr_commit && !wr_abort && !ovf_eff && (cnt_eff != '0) && wr_rdy;
  assign commit_bad = wr_commit && !wr_abort && !commit_ok;
  assign rel        = rd_done && rd_avail;

  // RAM output is undefined between responses; present zero when idle.
  assign rd_data = rd_dvld ? ram_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_cnt   <= '0;
      ovf      <= 1'b0;
      pend_cnt <= '0;
      wr_drop  <= 1'b0;
      rd_dvld  <= 1'b0;
      for (int i = 0; i < PAGE_NUM; i++) len_q[i] <= '0;
    end else begin
      wr_drop <= commit_bad;
      rd_dvld <= rd_req && rd_avail;

      if (wr_abort || wr_commit) begin
        wr_cnt <= '0;
        ovf    <= 1'b0;
      end else begin
        wr_cnt <= cnt_eff;
        ovf    <= ovf_eff;
      end

      if (commit_ok) begin
        len_q[wr_ptr] <= cnt_eff;
        wr_ptr        <= wr_ptr + PG_W'(1);
      end

      if (rel) rd_ptr <= rd_ptr + PG_W'(1);

      case ({commit_ok, rel})
        2'b10:   pend_cnt <= pend_cnt + (PG_W+1)'(1);
        2'b01:   pend_cnt <= pend_cnt - (PG_W+1)'(1);
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  // The write page is never a pending page, so read/write addresses never collide.
  cd_sdpram #(
    .A_WIDTH (A_W),
    .D_WIDTH (D_WIDTH)
  ) u_ram (
    .clk   (clk),
    .cen   (1'b0),
    .wen   (!acc),
    .waddr ({wr_ptr, wr_cnt[PAGE_AW-1:0]}),
    .wdata (wr_data),
    .raddr ({rd_ptr, rd_idx}),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_cd_page_ctrl.sv
// Bench for cd_page_ctrl: directed scenarios plus a randomized run, all checked
// against a frame-level queue model (list of frame lengths + flat byte list).
module tb_cd_page_ctrl;
  import cd_pkg::*;

  localparam int PN = 4;
  localparam int AW = 8;
  localparam int PSIZE = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_vld, wr_commit, wr_abort, rd_req, rd_done;
  logic [7:0] wr_data;
  logic [7:0] rd_idx;
  logic       wr_rdy, wr_drop, rd_avail, rd_dvld;
  logic [8:0] rd_len;
  logic [7:0] rd_data;
  logic [2:0] pend_cnt;

  int checks = 0;
  int errors = 0;

  // model state
  int   fq_len[$];
  logic [7:0] fq_data[$];
  logic [7:0] cur[$];
  bit   ovf_m;
  bit   exp_drop, exp_dvld, exp_data_ok;
  logic [7:0] exp_data;

  always #5 clk = ~clk;

  cd_page_ctrl #(.PAGE_NUM(PN), .PAGE_AW(AW), .D_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .wr_vld(wr_vld), .wr_data(wr_data), .wr_commit(wr_commit), .wr_abort(wr_abort),
    .wr_rdy(wr_rdy), .wr_drop(wr_drop),
    .rd_avail(rd_avail), .rd_len(rd_len),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_dvld(rd_dvld), .rd_data(rd_data),
    .rd_done(rd_done), .pend_cnt(pend_cnt)
  );

  task automatic model_clear();
    fq_len.delete(); fq_data.delete(); cur.delete();
    ovf_m = 0; exp_drop = 0; exp_dvld = 0; exp_data_ok = 0; exp_data = '0;
  endtask

  // Drive one cycle of inputs, advance the model over the edge, sample at +1.
  task automatic step(input bit vld, input logic [7:0] d, input bit cm, input bit ab,
                      input bit rq, input logic [7:0] ix, input bit dn);
    int n0;
    bit full;
    wr_vld = vld; wr_data = d; wr_commit = cm; wr_abort = ab;
    rd_req = rq; rd_idx = ix; rd_done = dn;
    n0 = fq_len.size();
    full = (n0 == PN);
    exp_dvld = rq && (n0 > 0);
    exp_data_ok = exp_dvld && (int'(ix) < fq_len[0]);
    if (exp_data_ok) exp_data = fq_data[ix];
    if (vld) begin
      if (!full && cur.size() < PSIZE) cur.push_back(d);
      else ovf_m = 1;
    end
    exp_drop = 0;
    if (ab) begin
      cur.delete(); ovf_m = 0;
    end else if (cm) begin
      if (!ovf_m && cur.size() > 0 && !full) begin
        fq_len.push_back(cur.size());
        foreach (cur[i]) fq_data.push_back(cur[i]);
      end else begin
        exp_drop = 1;
      end
      cur.delete(); ovf_m = 0;
    end
    if (dn && n0 > 0) begin
      repeat (fq_len[0]) void'(fq_data.pop_front());
      void'(fq_len.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic wbyte(input logic [7:0] d);
    step(1, d, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic commit();
    step(0, 8'h00, 1, 0, 0, 8'h00, 0);
  endtask

  task automatic release_one();
    step(0, 8'h00, 0, 0, 0, 8'h00, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_vld = 0; wr_data = 0; wr_commit = 0; wr_abort = 0;
    rd_req = 0; rd_idx = 0; rd_done = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    while (fq_len.size() > 0) release_one();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (wr_rdy !== 1'b1)   begin errors++; $display("FAIL reset_wr_rdy got %b want 1", wr_rdy); end
    checks++; if (wr_drop !== 1'b0)  begin errors++; $display("FAIL reset_wr_drop got %b want 0", wr_drop); end
    checks++; if (rd_avail !== 1'b0) begin errors++; $display("FAIL reset_rd_avail got %b want 0", rd_avail); end
    checks++; if (rd_len !== 9'd0)   begin errors++; $display("FAIL reset_rd_len got %0d want 0", rd_len); end
    checks++; if (rd_dvld !== 1'b0)  begin errors++; $display("FAIL reset_rd_dvld got %b want 0", rd_dvld); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL reset_pend got %0d want 0", pend_cnt); end
  endtask

  task automatic test_commit_read();
    logic [7:0] want [3];
    want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33;
    do_reset();
    for (int i = 0; i < 3; i++) wbyte(want[i]);
    commit();
    checks++; if (rd_avail !== 1'b1) begin errors++; $display("FAIL cr_avail got %b want 1", rd_avail); end
    checks++; if (rd_len !== 9'd3)   begin errors++; $display("FAIL cr_len got %0d want 3", rd_len); end
    checks++; if (pend_cnt !== 3'd1) begin errors++; $display("FAIL cr_pend got %0d want 1", pend_cnt); end
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 0, 0, 1, 8'(i), 0);
      checks++; if (rd_dvld !== 1'b1) begin errors++; $display("FAIL cr_dvld%0d got %b want 1", i, rd_dvld); end
      checks++; if (rd_data !== want[i]) begin errors++; $display("FAIL cr_data%0d got %h want %h", i, rd_data, want[i]); end
    end
    idle();
    checks++; if (rd_dvld !== 1'b0) begin errors++; $display("FAIL cr_dvld_pulse got %b want 0", rd_dvld); end
    release_one();
    checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL cr_release got %0d want 0", pend_cnt); end
    // a read while empty must be ignored
    step(0, 8'h00, 0, 0, 1, 8'h00, 0);
    checks++; if (rd_dvld !== 1'b0) begin errors++; $display("FAIL cr_empty_read got %b want 0", rd_dvld); end
  endtask

  task automatic test_queue_full();
    do_reset();
    for (int f = 1; f <= 4; f++) begin
      for (int b = 0; b < f; b++) wbyte(8'($urandom));
      commit();
    end
    checks++; if (wr_rdy !== 1'b0)   begin errors++; $display("FAIL qf_rdy got %b want 0", wr_rdy); end
    wbyte(8'hA5); wbyte(8'h5A);
    commit();
    checks++; if (wr_drop !== 1'b1)  begin errors++; $display("FAIL qf_drop got %b want 1", wr_drop); end
    checks++; if (pend_cnt !== 3'd4) begin errors++; $display("FAIL qf_pend got %0d want 4", pend_cnt); end
    idle();
    checks++; if (wr_drop !== 1'b0)  begin errors++; $display("FAIL qf_drop_pulse got %b want 0", wr_drop); end
    release_one();
    checks++; if (wr_rdy !== 1'b1)   begin errors++; $display("FAIL qf_rdy_after got %b want 1", wr_rdy); end
    checks++; if (rd_len !== 9'd2)   begin errors++; $display("FAIL qf_len_after got %0d want 2", rd_len); end
    drain();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 257; i++) wbyte(8'(i));
    commit();
    checks++; if (wr_drop !== 1'b1)  begin errors++; $display("FAIL ov_drop got %b want 1", wr_drop); end
    checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL ov_pend got %0d want 0", pend_cnt); end
    for (int i = 0; i < 256; i++) wbyte(8'(i ^ 8'h5C));
    commit();
    checks++; if (wr_drop !== 1'b0)  begin errors++; $display("FAIL ov_full_drop got %b want 0", wr_drop); end
    checks++; if (rd_len !== 9'd256) begin errors++; $display("FAIL ov_len got %0d want 256", rd_len); end
    step(0, 8'h00, 0, 0, 1, 8'd255, 0);
    checks++; if (rd_data !== 8'(255 ^ 8'h5C)) begin errors++; $display("FAIL ov_last got %h want %h", rd_data, 8'(255 ^ 8'h5C)); end
    drain();
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 3; i++) wbyte(8'($urandom));
    commit();
    for (int i = 0; i < 5; i++) wbyte(8'($urandom));
    commit();
    wbyte(8'h01); wbyte(8'h02);
    step(0, 8'h00, 1, 0, 0, 8'h00, 1);
    checks++; if (pend_cnt !== 3'd2) begin errors++; $display("FAIL sim_pend got %0d want 2", pend_cnt); end
    checks++; if (rd_len !== 9'd5)   begin errors++; $display("FAIL sim_len got %0d want 5", rd_len); end
    drain();
    wbyte(8'hC3);
    step(1, 8'h3C, 1, 0, 0, 8'h00, 0);
    checks++; if (rd_len !== 9'd2)   begin errors++; $display("FAIL sim_vld_commit_len got %0d want 2", rd_len); end
    step(0, 8'h00, 0, 0, 1, 8'd1, 0);
    checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL sim_vld_commit_data got %h want 3c", rd_data); end
    // read in the same cycle as release returns data from the released frame
    step(0, 8'h00, 0, 0, 1, 8'd0, 1);
    checks++; if (rd_data !== 8'hC3) begin errors++; $display("FAIL sim_read_release got %h want c3", rd_data); end
    drain();
  endtask

  task automatic test_abort_empty();
    do_reset();
    for (int i = 0; i < 5; i++) wbyte(8'hE0 + 8'(i));
    step(0, 8'h00, 0, 1, 0, 8'h00, 0);
    checks++; if (wr_drop !== 1'b0)  begin errors++; $display("FAIL ab_drop got %b want 0", wr_drop); end
    checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL ab_pend got %0d want 0", pend_cnt); end
    wbyte(8'h77); wbyte(8'h88);
    commit();
    checks++; if (rd_len !== 9'd2)   begin errors++; $display("FAIL ab_next_len got %0d want 2", rd_len); end
    step(0, 8'h00, 0, 0, 1, 8'd0, 0);
    checks++; if (rd_data !== 8'h77) begin errors++; $display("FAIL ab_next_idx0 got %h want 77", rd_data); end
    drain();
    commit();
    checks++; if (wr_drop !== 1'b1)  begin errors++; $display("FAIL empty_commit_drop got %b want 1", wr_drop); end
    release_one();
    checks++; if (pend_cnt !== 3'd0) begin errors++; $display("FAIL empty_done got %0d want 0", pend_cnt); end
    // commit and abort together: abort wins, no frame, no drop
    wbyte(8'h10);
    step(0, 8'h00, 1, 1, 0, 8'h00, 0);
    checks++; if (pend_cnt !== 3'd0 || wr_drop !== 1'b0) begin errors++; $display("FAIL ab_vs_commit pend %0d drop %b want 0 0", pend_cnt, wr_drop); end
  endtask

  task automatic test_wrap();
    int len;
    int bad;
    do_reset();
    for (int f = 0; f < 10; f++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) wbyte(8'($urandom));
      commit();
      checks++; if (int'(rd_len) !== len) begin errors++; $display("FAIL wrap_len%0d got %0d want %0d", f, rd_len, len); end
      bad = 0;
      for (int i = 0; i < len; i++) begin
        step(0, 8'h00, 0, 0, 1, 8'(i), 0);
        if (rd_dvld !== 1'b1 || rd_data !== exp_data) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL wrap_data%0d got %0d bad bytes want 0", f, bad); end
      release_one();
    end
  endtask

  task automatic test_random();
    bit vld, cm, ab, rq, dn;
    int ix;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      vld = ($urandom_range(0, 99) < 60);
      cm  = ($urandom_range(0, 99) < 7);
      ab  = ($urandom_range(0, 99) < 2);
      rq  = ($urandom_range(0, 99) < 35);
      dn  = ($urandom_range(0, 99) < 5);
      ix  = (fq_len.size() > 0) ? $urandom_range(0, fq_len[0] - 1) : $urandom_range(0, 255);
      step(vld, 8'($urandom), cm, ab, rq, 8'(ix), dn);
      checks++;
      if (int'(pend_cnt) !== fq_len.size() || wr_rdy !== (fq_len.size() != PN) ||
          rd_avail !== (fq_len.size() != 0) || wr_drop !== exp_drop || rd_dvld !== exp_dvld) begin
        errors++;
        $display("FAIL rnd_ctl cyc %0d got pend %0d rdy %b avail %b drop %b dvld %b want %0d %b %b %b %b",
                 c, pend_cnt, wr_rdy, rd_avail, wr_drop, rd_dvld,
                 fq_len.size(), fq_len.size() != PN, fq_len.size() != 0, exp_drop, exp_dvld);
      end
      if (exp_data_ok) begin
        checks++;
        if (rd_data !== exp_data) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", c, rd_data, exp_data); end
      end
      if (fq_len.size() > 0) begin
        checks++;
        if (int'(rd_len) !== fq_len[0]) begin errors++; $display("FAIL rnd_len cyc %0d got %0d want %0d", c, rd_len, fq_len[0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    len_t l;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) wbyte(8'($urandom));
      commit();
    end
    wbyte(8'h99);
    step(0, 8'h00, 0, 0, 1, 8'd0, 0);
    reset = 1'b1;
    wr_vld = 1; wr_data = 8'h42; wr_commit = 1; rd_req = 1; rd_done = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    wr_vld = 0; wr_commit = 0; rd_req = 0;
    model_clear();
    l = rd_len;
    checks++; if (pend_cnt !== 3'd0 || rd_avail !== 1'b0 || wr_rdy !== 1'b1) begin errors++; $display("FAIL rm_ctl got pend %0d avail %b rdy %b want 0 0 1", pend_cnt, rd_avail, wr_rdy); end
    checks++; if (l !== '0 || wr_drop !== 1'b0 || rd_dvld !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("FAIL rm_out got len %0d drop %b dvld %b data %h want 0 0 0 00", l, wr_drop, rd_dvld, rd_data); end
    idle();
    checks++; if (wr_drop !== 1'b0 || pend_cnt !== 3'd0) begin errors++; $display("FAIL rm_after got drop %b pend %0d want 0 0", wr_drop, pend_cnt); end
  endtask

  initial begin
    test_reset();
    test_commit_read();
    test_queue_full();
    test_overflow();
    test_simultaneous();
    test_abort_empty();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
